// File: rtl/codec_sample_buffer_pkg.sv
// codec_sample_buffer_pkg
//   Shared constants and types for the codec sample buffer:
//   FIFO depth, prime threshold, sample width and FSM state encoding.
package codec_sample_buffer_pkg;

    localparam int unsigned DEPTH       = 8;
    localparam int unsigned PRIME_LEVEL = 4;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
    localparam int unsigned UF_W        = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/codec_sample_buffer_fifo.sv
// sample_fifo
//   DEPTH-entry sample FIFO with wrap-around pointers.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     flush             empties the FIFO (has priority over push/pop)
//     push, wdata       write request and data; ignored when full unless
//                       a pop in the same cycle frees a slot
//     pop               read request; ignored when empty
//     rdata             current head entry (valid when not empty)
//     full, empty       status flags
//     count             number of stored entries, 0..DEPTH
module sample_fifo
    import codec_sample_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  sample_t          wdata,
    input  logic             pop,
    output sample_t          rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    sample_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/codec_sample_buffer.sv
// codec_sample_buffer
//   Buffers samples from a music player and hands one to the codec on each
//   rising edge of new_frame. Primes the FIFO to PRIME_LEVEL before playout.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     play_enable       player is in play state
//     new_sample_in     strobe: sample_in valid this cycle
//     sample_in         signed sample from the player
//     new_frame         codec frame level (rising edge = frame tick)
//     generate_next     one-cycle request to the player for a sample
//     sample_to_codec   registered sample presented to the codec
//     fill_level        stored sample count, 0..8
//     underflow_count   saturating underflow counter
//     overflow          sticky dropped-sample flag
module codec_sample_buffer
    import codec_sample_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             play_enable,
    input  logic             new_sample_in,
    input  sample_t          sample_in,
    input  logic             new_frame,
    output logic             generate_next,
    output sample_t          sample_to_codec,
    output logic [CNT_W-1:0] fill_level,
    output logic [UF_W-1:0]  underflow_count,
    output logic             overflow
);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_new_frame_d;
    logic            r_req;
    logic            r_gen;
    sample_t         r_sample;
    logic [UF_W-1:0] r_uf_count;
    logic            r_overflow;

    logic             w_frame_tick;
    logic             w_active;
    logic             w_flush;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    sample_t          w_head;
    logic             w_gen_next;

    assign w_frame_tick = new_frame && !r_new_frame_d;

    sample_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (w_flush),
        .push  (w_push),
        .wdata (sample_in),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // w_active: staying in PRIME/RUN this cycle; dropping play_enable
    // leaves immediately, so the FIFO is flushed on that same edge.
    always_comb begin
        w_next_state = r_state;
        w_active     = 1'b0;
        w_flush      = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_flush = 1'b1;
                if (play_enable) begin
                    w_next_state = PRIME;
                end
            end
            PRIME: begin
                if (!play_enable) begin
                    w_next_state = IDLE;
                    w_flush      = 1'b1;
                end else begin
                    w_active = 1'b1;
                    if (w_count >= CNT_W'(PRIME_LEVEL)) begin
                        w_next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (!play_enable) begin
                    w_next_state = IDLE;
                    w_flush      = 1'b1;
                end else begin
                    w_active = 1'b1;
                    w_pop    = w_frame_tick;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_flush      = 1'b1;
            end
        endcase
    end

    assign w_push = new_sample_in && w_active;
    // The r_gen term keeps requests from landing on adjacent cycles before
    // r_req has caught up.
    assign w_gen_next = w_active && !r_req && !r_gen && !w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_new_frame_d <= 1'b0;
            r_req         <= 1'b0;
            r_gen         <= 1'b0;
            r_sample      <= '0;
            r_uf_count    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_new_frame_d <= new_frame;
            r_gen         <= w_gen_next;

            if (!w_active) begin
                r_req <= 1'b0;
            end else if (r_gen) begin
                r_req <= 1'b1;
            end else if (new_sample_in) begin
                r_req <= 1'b0;
            end

            if (!w_active) begin
                r_sample <= '0;
            end else if (r_state == PRIME && w_frame_tick) begin
                r_sample <= '0;
            end else if (w_pop) begin
                r_sample <= w_empty ? '0 : w_head;
            end

            if (w_pop && w_empty && (r_uf_count != '1)) begin
                r_uf_count <= r_uf_count + UF_W'(1);
            end

            // Full implies non-empty, so any pop here frees a slot.
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign generate_next   = r_gen;
    assign sample_to_codec = r_sample;
    assign fill_level      = w_count;
    assign underflow_count = r_uf_count;
    assign overflow        = r_overflow;

endmodule
